rf_wb_arbiter: RTL and testbench

Shares the single register-file write port of the openmips core between three writers: the pipeline write-back stage (wb), a long-latency multi-cycle unit such as a divider (mc), and a debug/loader port (dbg). It sits between those sources and the regfile write inputs, and drives registered write signals into the regfile. It prevents starvation of mc by raising a pipeline stall request.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_wb_arbiter_rr.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and the regfile.
package rf_wb_arbiter_pkg;

   // Register-file geometry, shared with the regfile itself.
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   // Register 0 is hard-wired to zero; writes to it are swallowed.
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

   // Source of the write currently presented to the regfile.
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_WB   = 2'b01,
      GNT_MC   = 2'b10,
      GNT_DBG  = 2'b11
   } grant_src_e;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Two-requester round-robin arbiter with a priority override for requester 0.
// Requester 0 is the multi-cycle unit, requester 1 the debug port.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,    // asynchronous, active-low
   input  logic en,     // arbitration allowed this cycle (port not taken by wb)
   input  logic ovr,    // force requester 0 ahead and lock out requester 1
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // ptr = 0: requester 0 has priority next; ptr = 1: requester 1 has priority.
   logic ptr_q, ptr_d;

   // Grant decision and pointer advance after every granted transfer.
   always_comb begin
      gnt0  = en & req0 & (ovr | ~req1 | ~ptr_q);
      gnt1  = en & req1 & ~ovr & (~req0 | ptr_q);
      ptr_d = ptr_q;
      if (gnt0) begin
         ptr_d = 1'b1;
      end else if (gnt1) begin
         ptr_d = 1'b0;
      end
   end

   // Pointer register; reset favours requester 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: write-back stage always wins, the
// multi-cycle unit and debug port share the remaining slots round-robin, and
// a stall request is raised when the multi-cycle unit waits too long.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DATA_W     = RF_DATA_W,
   parameter int ADDR_W     = RF_ADDR_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              mc_valid,
   input  logic [ADDR_W-1:0] mc_waddr,
   input  logic [DATA_W-1:0] mc_wdata,
   output logic              mc_ready,
   input  logic              dbg_valid,
   input  logic [ADDR_W-1:0] dbg_waddr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [1:0]        grant_src,
   output logic              stall_req
);

   localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(RF_ZERO_ADDR);

   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   grant_src_e        grant_q, grant_d;
   logic              stall_q, stall_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;

   logic wb_gnt, mc_gnt, dbg_gnt;

   // wb has no backpressure, so it pre-empts the shared arbiter outright.
   assign wb_gnt = rst & wb_we;

   rr_arbiter2 u_rr (
      .clk  (clk),
      .rst  (rst),
      .en   (rst & ~wb_we),
      .ovr  (stall_q),
      .req0 (mc_valid),
      .req1 (dbg_valid),
      .gnt0 (mc_gnt),
      .gnt1 (dbg_gnt)
   );

   assign mc_ready  = mc_gnt;
   assign dbg_ready = dbg_gnt;

   // Select the winning write; register 0 writes complete but never enable the regfile.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      grant_d    = GNT_NONE;
      if (wb_gnt) begin
         rf_waddr_d = wb_waddr;
         rf_wdata_d = wb_wdata;
         grant_d    = GNT_WB;
      end else if (mc_gnt) begin
         rf_waddr_d = mc_waddr;
         rf_wdata_d = mc_wdata;
         grant_d    = GNT_MC;
      end else if (dbg_gnt) begin
         rf_waddr_d = dbg_waddr;
         rf_wdata_d = dbg_wdata;
         grant_d    = GNT_DBG;
      end
      rf_we_d = (grant_d != GNT_NONE) && (rf_waddr_d != ZERO_ADDR);
   end

   // Starvation tracking: a transfer or a withdrawn request always wins over saturation.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      stall_d    = stall_q;
      if (!mc_valid || mc_gnt) begin
         wait_cnt_d = '0;
         stall_d    = 1'b0;
      end else begin
         if (wait_cnt_q != STARVE_LIM) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
         if (wait_cnt_d == STARVE_LIM) begin
            stall_d = 1'b1;
         end
      end
   end

   // Output and starvation state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         grant_q    <= GNT_NONE;
         stall_q    <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         grant_q    <= grant_d;
         stall_q    <= stall_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign grant_src = grant_q;
   assign stall_req = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: the stimulus process pushes the expected
// regfile write for every grant it causes; a monitor pops and compares each
// write the DUT presents.
module tb_rf_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    src;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wb_we = 1'b0;
   logic [AW-1:0] wb_waddr = '0;
   logic [DW-1:0] wb_wdata = '0;
   logic          mc_valid = 1'b0;
   logic [AW-1:0] mc_waddr = '0;
   logic [DW-1:0] mc_wdata = '0;
   logic          mc_ready;
   logic          dbg_valid = 1'b0;
   logic [AW-1:0] dbg_waddr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          dbg_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [1:0]    grant_src;
   logic          stall_req;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   bit   done = 1'b0;

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
      .dbg_valid(dbg_valid), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .grant_src(grant_src), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] s);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.src = s;
      sb_q.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_we = v; wb_waddr = a; wb_wdata = d;
   endtask

   task automatic set_mc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mc_valid = v; mc_waddr = a; mc_wdata = d;
   endtask

   task automatic set_dbg(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_valid = v; dbg_waddr = a; dbg_wdata = d;
   endtask

   task automatic idle_all();
      set_wb(1'b0, '0, '0);
      set_mc(1'b0, '0, '0);
      set_dbg(1'b0, '0, '0);
   endtask

   task automatic reset_pulse();
      next_cycle();
      idle_all();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
   endtask

   // Monitor: every presented write (grant_src != 00) must match the scoreboard head.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #3;
         if (grant_src != 2'b00) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got src=%b addr=%0d with empty scoreboard",
                        grant_src, rf_waddr);
            end else begin
               e = sb_q.pop_front();
               chk("mon_src", 32'(grant_src), 32'(e.src));
               chk("mon_we", 32'(rf_we), 32'(e.we));
               if (e.we) begin
                  chk("mon_addr", 32'(rf_waddr), 32'(e.addr));
                  chk("mon_data", rf_wdata, e.data);
               end
            end
         end
      end
   end

   initial begin
      // Reset held with active requests: nothing may be granted.
      rst = 1'b0;
      set_wb(1'b1, 5'd1, 32'h01010000);
      set_mc(1'b1, 5'd6, 32'h00000606);
      repeat (3) next_cycle();
      #1;
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_grant", 32'(grant_src), 0);
      chk("rst_stall", 32'(stall_req), 0);
      chk("rst_mc_ready", 32'(mc_ready), 0);
      chk("rst_dbg_ready", 32'(dbg_ready), 0);

      // Release: wb wins at once, mc follows once wb goes quiet.
      next_cycle();
      rst = 1'b1;
      #1;
      chk("rel_mc_ready_wb_busy", 32'(mc_ready), 0);
      push(1'b1, 5'd1, 32'h01010000, 2'b01);
      next_cycle();
      set_wb(1'b0, '0, '0);
      #1;
      chk("rel_mc_ready", 32'(mc_ready), 1);
      push(1'b1, 5'd6, 32'h00000606, 2'b10);
      next_cycle();
      set_mc(1'b0, '0, '0);
      next_cycle();
      #1;
      chk("idle_rf_we", 32'(rf_we), 0);
      chk("idle_grant", 32'(grant_src), 0);

      // Single wb write with a different pattern.
      set_wb(1'b1, 5'd7, 32'hDEADBEEF);
      push(1'b1, 5'd7, 32'hDEADBEEF, 2'b01);
      next_cycle();
      set_wb(1'b0, '0, '0);

      // mc and dbg together after reset: mc first, then dbg.
      reset_pulse();
      set_mc(1'b1, 5'd2, 32'h01011101);
      set_dbg(1'b1, 5'd3, 32'h0000FF00);
      #1;
      chk("rr_mc_ready_c0", 32'(mc_ready), 1);
      chk("rr_dbg_ready_c0", 32'(dbg_ready), 0);
      push(1'b1, 5'd2, 32'h01011101, 2'b10);
      next_cycle();
      set_mc(1'b0, '0, '0);
      #1;
      chk("rr_dbg_ready_c1", 32'(dbg_ready), 1);
      push(1'b1, 5'd3, 32'h0000FF00, 2'b11);
      next_cycle();
      set_dbg(1'b0, '0, '0);

      // Write to register 0: handshake completes, regfile not enabled.
      next_cycle();
      set_dbg(1'b1, 5'd0, 32'hFFFF00FF);
      #1;
      chk("zero_dbg_ready", 32'(dbg_ready), 1);
      push(1'b0, 5'd0, 32'hFFFF00FF, 2'b11);
      next_cycle();
      set_dbg(1'b0, '0, '0);

      // Starvation: wb hogs the port for 4 cycles while mc waits.
      reset_pulse();
      set_mc(1'b1, 5'd4, 32'h00000000);
      for (int i = 0; i < 4; i++) begin
         set_wb(1'b1, 5'd8, 32'h00000080 + 32'(i));
         #1;
         chk("starve_mc_ready", 32'(mc_ready), 0);
         chk("starve_stall_low", 32'(stall_req), 0);
         push(1'b1, 5'd8, 32'h00000080 + 32'(i), 2'b01);
         next_cycle();
      end
      set_wb(1'b0, '0, '0);
      set_dbg(1'b1, 5'd9, 32'h00000099);
      #1;
      chk("starve_stall_high", 32'(stall_req), 1);
      chk("starve_mc_ready_win", 32'(mc_ready), 1);
      chk("starve_dbg_blocked", 32'(dbg_ready), 0);
      push(1'b1, 5'd4, 32'h00000000, 2'b10);
      next_cycle();
      set_mc(1'b0, '0, '0);
      #1;
      chk("starve_stall_clear", 32'(stall_req), 0);
      chk("starve_dbg_after", 32'(dbg_ready), 1);
      push(1'b1, 5'd9, 32'h00000099, 2'b11);
      next_cycle();
      set_dbg(1'b0, '0, '0);

      // wb still wins under stall; reset mid-stall clears it immediately.
      reset_pulse();
      set_mc(1'b1, 5'd10, 32'hA5A5A5A5);
      for (int i = 0; i < 5; i++) begin
         set_wb(1'b1, 5'd11, 32'h00000B00 + 32'(i));
         push(1'b1, 5'd11, 32'h00000B00 + 32'(i), 2'b01);
         next_cycle();
      end
      set_wb(1'b0, '0, '0);
      #1;
      chk("wb_under_stall_keeps_stall", 32'(stall_req), 1);
      #3;
      rst = 1'b0;
      #1;
      chk("midstall_rst_stall", 32'(stall_req), 0);
      chk("midstall_rst_mc_ready", 32'(mc_ready), 0);
      next_cycle();
      rst = 1'b1;
      #1;
      chk("post_rst_mc_ready", 32'(mc_ready), 1);
      chk("post_rst_stall", 32'(stall_req), 0);
      push(1'b1, 5'd10, 32'hA5A5A5A5, 2'b10);
      next_cycle();
      set_mc(1'b0, '0, '0);

      repeat (3) next_cycle();
      chk("scoreboard_drained", 32'(sb_q.size()), 0);
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
